// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared types, burst constants and round-robin pick for the SRAM transfer arbiter
package sram_arb_pkg;

    localparam int CNT_W     = 7;
    localparam int BURST_LEN = 2 ** CNT_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

    // First requester at or after ptr, wrapping modulo n (n <= 4); lowest offset wins.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr, input int n);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = ptr;
        for (int i = 3; i >= 0; i--) begin
            idx = 2'((int'(ptr) + i) % n);
            if (i < n && req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/xfer_word_counter.sv
// rtl/xfer_word_counter.sv - per-word burst counter, wraps from all-ones to zero
module xfer_word_counter #(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             rollover
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count    = count_q;
    assign rollover = (count_q == '1);

endmodule

// File: rtl/sram_xfer_arbiter.sv
// rtl/sram_xfer_arbiter.sv - round-robin arbiter sequencing fixed-length block bursts on a single-port SRAM
module sram_xfer_arbiter #(
    parameter int N_REQ  = 2,
    parameter int DATA_W = 16,
    parameter int BLK_W  = 5,
    parameter int CNT_W  = sram_arb_pkg::CNT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         is_write,
    input  logic [N_REQ*BLK_W-1:0]   blk_idx,
    input  logic [N_REQ*DATA_W-1:0]  wdata,
    output logic [N_REQ-1:0]         gnt,
    output logic                     word_strobe,
    output logic [CNT_W-1:0]         word_idx,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic [N_REQ-1:0]         done,
    output logic                     sram_en,
    output logic                     sram_we,
    output logic [BLK_W+CNT_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata
);
    import sram_arb_pkg::*;

    localparam int IDX_W = (N_REQ > 2) ? 2 : 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick;
    logic             we_q, we_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    logic             rvalid_q, rvalid_d;
    logic [CNT_W-1:0] count;
    logic             rollover;
    logic             xfer;
    logic             busy;

    assign xfer = (state_q == ST_XFER);
    assign busy = xfer || (state_q == ST_DRAIN);
    assign pick = IDX_W'(rr_pick(4'(req), 2'(ptr_q), N_REQ));

    // Counter is only ever cleared while idle, so a burst always runs its full length.
    xfer_word_counter #(.CNT_W(CNT_W)) u_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_q == ST_IDLE),
        .enable   (xfer),
        .count    (count),
        .rollover (rollover)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        we_d    = we_q;
        blk_d   = blk_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    idx_d   = pick;
                    we_d    = is_write[pick];
                    blk_d   = blk_idx[int'(pick)*BLK_W +: BLK_W];
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rollover) begin
                    state_d = we_q ? ST_DONE : ST_DRAIN;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE: begin
                ptr_d   = (int'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read data returns one cycle after the strobe, so the valid is the strobe delayed.
    assign rvalid_d = xfer && !we_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            ptr_q    <= '0;
            we_q     <= 1'b0;
            blk_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ptr_q    <= ptr_d;
            we_q     <= we_d;
            blk_q    <= blk_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_comb begin
        gnt  = '0;
        done = '0;
        for (int i = 0; i < N_REQ; i++) begin
            gnt[i]  = busy && (idx_q == IDX_W'(i));
            done[i] = (state_q == ST_DONE) && (idx_q == IDX_W'(i));
        end
    end

    assign word_strobe = xfer;
    assign word_idx    = xfer ? count : '0;
    assign sram_en     = xfer;
    assign sram_we     = xfer && we_q;
    assign sram_addr   = xfer ? {blk_q, count} : '0;
    assign sram_wdata  = (xfer && we_q) ? wdata[int'(idx_q)*DATA_W +: DATA_W] : '0;
    assign rvalid      = rvalid_q;
    assign rdata       = rvalid_q ? sram_rdata : '0;

endmodule
